// File: rtl/towerplacer_control.sv
// Tower-placer sequencer: key edges -> one-hot datapath strobes, cursor/credit/occupancy tracking.
// Define OCCUPANCY_CHECK_EN to build the per-cell occupancy map and refuse placement on used cells.
module towerplacer_control #(
    parameter int GRID_COLS   = 8,
    parameter int GRID_ROWS   = 6,
    parameter int TOWER_COST  = 10,
    parameter int KILL_REWARD = 2,
    parameter int CREDIT_INIT = 20,
    parameter int MIN_DRAW    = 400,
    parameter int TIMEOUT     = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_right,
    input  logic       key_down,
    input  logic       key_place,
    input  logic       credit_in,
    input  logic       square_done,
    input  logic       erase_done,
    input  logic       tower_done,
    input  logic       valid,
    output logic       top_left,
    output logic       draw_square,
    output logic       move_right,
    output logic       move_down,
    output logic       move_right_wait,
    output logic       move_down_wait,
    output logic       draw_tower,
    output logic       erase_square_right,
    output logic       erase_square_down,
    output logic       erase_square_tower,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic [9:0] credits,
    output logic       busy,
    output logic       place_ok,
    output logic       place_rej,
    output logic       timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_TL, S_DRAW_SQ, S_IDLE,
        S_ERASE_R, S_MOVE_R, S_MOVE_R_WAIT,
        S_ERASE_D, S_MOVE_D, S_MOVE_D_WAIT,
        S_ERASE_T, S_TOWER
    } state_t;

    // Strobe order: top_left .. erase_square_tower, MSB first.
    function automatic logic [9:0] decode_strobes(input state_t s);
        logic [9:0] v;
        case (s)
            S_TL:          v = 10'b10_0000_0000;
            S_DRAW_SQ:     v = 10'b01_0000_0000;
            S_MOVE_R:      v = 10'b00_1000_0000;
            S_MOVE_D:      v = 10'b00_0100_0000;
            S_MOVE_R_WAIT: v = 10'b00_0010_0000;
            S_MOVE_D_WAIT: v = 10'b00_0001_0000;
            S_TOWER:       v = 10'b00_0000_1000;
            S_ERASE_R:     v = 10'b00_0000_0100;
            S_ERASE_D:     v = 10'b00_0000_0010;
            S_ERASE_T:     v = 10'b00_0000_0001;
            default:       v = 10'b00_0000_0000;
        endcase
        return v;
    endfunction

    state_t             state_q, state_d, case_next_s, done_next_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         keys_q, keys_d, keys_now_s, edge_s;
    logic [2:0]         x_q, x_d, y_q, y_d;
    logic [9:0]         credits_q, credits_d;
    logic [10:0]        credit_sum_s;
    logic               ok_q, ok_d, rej_q, rej_d, err_q, err_d;
    logic [9:0]         strobe_q;
    logic               busy_q;
    logic               timed_s, done_s, adv_s, expire_s, accept_s, place_allowed_s;

`ifdef OCCUPANCY_CHECK_EN
    localparam int CELLS  = GRID_COLS * GRID_ROWS;
    localparam int CELL_W = $clog2(CELLS);
    logic [CELLS-1:0]  occ_q, occ_d;
    logic [CELL_W-1:0] cell_idx_s;

    assign cell_idx_s      = CELL_W'(int'(y_q) * GRID_COLS + int'(x_q));
    assign place_allowed_s = (credits_q >= 10'(TOWER_COST)) && !occ_q[cell_idx_s];
    assign occ_d           = accept_s ? (occ_q | ({{(CELLS-1){1'b0}}, 1'b1} << cell_idx_s)) : occ_q;

    // Occupancy map: one bit per cell, set on each accepted placement.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            occ_q <= {CELLS{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end
`else
    assign place_allowed_s = (credits_q >= 10'(TOWER_COST));
`endif

    assign keys_now_s = {key_place, key_down, key_right};
    assign edge_s     = keys_now_s & ~keys_q;

    // Next-state, cursor, credit and pulse logic.
    always_comb begin
        case_next_s = state_q;
        done_next_s = S_IDLE;
        timed_s     = 1'b0;
        done_s      = 1'b0;
        accept_s    = 1'b0;
        ok_d        = 1'b0;
        rej_d       = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        keys_d      = keys_now_s;
        case (state_q)
            S_TL:          case_next_s = S_DRAW_SQ;
            S_DRAW_SQ:     begin timed_s = 1'b1; done_s = square_done; done_next_s = S_IDLE; end
            S_IDLE: begin
                if (edge_s[2]) begin
                    if (place_allowed_s) begin
                        accept_s    = 1'b1;
                        ok_d        = 1'b1;
                        case_next_s = S_ERASE_T;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (edge_s[0]) begin
                    case_next_s = S_ERASE_R;
                end else if (edge_s[1]) begin
                    case_next_s = S_ERASE_D;
                end else begin
                    case_next_s = S_IDLE;
                end
            end
            S_ERASE_R:     begin timed_s = 1'b1; done_s = erase_done; done_next_s = S_MOVE_R; end
            S_MOVE_R: begin
                if (valid) begin
                    x_d         = (x_q == 3'(GRID_COLS - 1)) ? 3'd0 : x_q + 3'd1;
                    case_next_s = S_MOVE_R_WAIT;
                end else begin
                    case_next_s = S_MOVE_R;
                end
            end
            S_MOVE_R_WAIT: case_next_s = S_DRAW_SQ;
            S_ERASE_D:     begin timed_s = 1'b1; done_s = erase_done; done_next_s = S_MOVE_D; end
            S_MOVE_D: begin
                if (valid) begin
                    y_d         = (y_q == 3'(GRID_ROWS - 1)) ? 3'd0 : y_q + 3'd1;
                    case_next_s = S_MOVE_D_WAIT;
                end else begin
                    case_next_s = S_MOVE_D;
                end
            end
            S_MOVE_D_WAIT: case_next_s = S_DRAW_SQ;
            S_ERASE_T:     begin timed_s = 1'b1; done_s = erase_done; done_next_s = S_TOWER; end
            S_TOWER:       begin timed_s = 1'b1; done_s = tower_done; done_next_s = S_DRAW_SQ; end
            default:       case_next_s = S_TL;
        endcase

        // A done flag only counts once the state has lasted MIN_DRAW cycles; stale flags are masked.
        adv_s    = timed_s && done_s && (cnt_q >= CNT_W'(MIN_DRAW));
        expire_s = timed_s && !adv_s && (cnt_q >= CNT_W'(TIMEOUT - 1));
        state_d  = adv_s ? done_next_s : (expire_s ? S_TL : case_next_s);
        err_d    = err_q | expire_s;
        cnt_d    = (state_d != state_q) ? CNT_W'(0) : cnt_q + CNT_W'(1);

        credit_sum_s = {1'b0, credits_q}
                     + (credit_in ? 11'(KILL_REWARD) : 11'd0)
                     - (accept_s ? 11'(TOWER_COST) : 11'd0);
        credits_d    = (credit_sum_s > 11'd1023) ? 10'd1023 : credit_sum_s[9:0];
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_TL;
            cnt_q     <= CNT_W'(0);
            keys_q    <= keys_now_s;
            x_q       <= 3'd0;
            y_q       <= 3'd0;
            credits_q <= 10'(CREDIT_INIT);
            ok_q      <= 1'b0;
            rej_q     <= 1'b0;
            err_q     <= 1'b0;
            strobe_q  <= decode_strobes(S_TL);
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            keys_q    <= keys_d;
            x_q       <= x_d;
            y_q       <= y_d;
            credits_q <= credits_d;
            ok_q      <= ok_d;
            rej_q     <= rej_d;
            err_q     <= err_d;
            strobe_q  <= decode_strobes(state_d);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign {top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait,
            draw_tower, erase_square_right, erase_square_down, erase_square_tower} = strobe_q;
    assign cursor_x    = x_q;
    assign cursor_y    = y_q;
    assign credits     = credits_q;
    assign busy        = busy_q;
    assign place_ok    = ok_q;
    assign place_rej   = rej_q;
    assign timeout_err = err_q;
endmodule
